// File: rtl/sparce_skip_unit.sv
// sparce_skip_unit: tracks zero-valued registers and redirects fetch past
// software-registered skippable regions whose operands are known sparse.
module sparce_skip_unit #(
  parameter int          SASA_ENTRIES = 4,
  parameter logic [31:0] SASA_BASE    = 32'h0000_9000,
  parameter int          HOLDOFF      = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc,
  input  logic [31:0] rdata,
  input  logic        if_ex_enable,
  input  logic        wb_en,
  input  logic [4:0]  rd,
  input  logic [31:0] wb_data,
  input  logic        sasa_wen,
  input  logic [31:0] sasa_addr,
  input  logic [31:0] sasa_data,
  output logic [31:0] sparce_target,
  output logic        skipping
);
  localparam int          IW    = SASA_ENTRIES > 1 ? $clog2(SASA_ENTRIES) : 1;
  localparam int          HW    = HOLDOFF > 1 ? $clog2(HOLDOFF) : 1;
  localparam logic [31:0] WIN   = 32'(SASA_ENTRIES * 8);
  localparam logic [HW-1:0] HLAST = HW'(HOLDOFF - 1);

  typedef enum logic [1:0] {IDLE, SKIP, HOLD} state_t;

  state_t                          state_q;
  logic [HW-1:0]                   hold_q;
  logic [31:0]                     target_q;
  logic                            skipping_q;
  logic [31:0]                     svrf_q, svrf_d;
  logic [31:0][1:0]                pend_q;
  logic [SASA_ENTRIES-1:0][31:0]   trig_q;
  logic [SASA_ENTRIES-1:0]         valid_q, cond_q;
  logic [SASA_ENTRIES-1:0][4:0]    rs1_q, rs2_q;
  logic [SASA_ENTRIES-1:0][7:0]    skip_q;

  logic [31:0]   off;
  logic [IW-1:0] widx;
  logic          win_ok;
  logic [6:0]    opc;
  logic          writer, inc;
  logic [31:0]   inc_vec, dec_vec, sparse;
  logic          hit, hit_cond, fire;
  logic [31:0]   hit_target;
  logic          unused_bits;

  assign off         = sasa_addr - SASA_BASE;
  assign widx        = off[3 +: IW];
  assign win_ok      = sasa_wen && (off < WIN);
  assign opc         = rdata[6:0];
  assign writer      = opc == 7'b0110111 || opc == 7'b0010111 || opc == 7'b1101111 ||
                       opc == 7'b1100111 || opc == 7'b0000011 || opc == 7'b0010011 ||
                       opc == 7'b0110011 || opc == 7'b1110011;
  assign inc         = if_ex_enable && writer && rdata[11:7] != 5'd0;
  assign inc_vec     = inc ? 32'd1 << rdata[11:7] : 32'd0;
  assign dec_vec     = (wb_en && rd != 5'd0) ? 32'd1 << rd : 32'd0;
  assign unused_bits = ^{rdata[31:12], sasa_data[29:21], sasa_data[15:13]};

  // Writeback is forwarded so a lookup sees the value being written this cycle.
  always_comb begin
    svrf_d = svrf_q;
    if (wb_en && rd != 5'd0) svrf_d[rd] = wb_data == 32'd0;
  end

  always_comb begin
    sparse = '0;
    for (int r = 0; r < 32; r++) sparse[r] = (r == 0) || (svrf_d[r] && pend_q[r] == 2'd0);
  end

  // Walk high-to-low so the lowest matching index is the one left standing.
  always_comb begin
    hit        = 1'b0;
    hit_cond   = 1'b0;
    hit_target = '0;
    for (int i = SASA_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && skip_q[i] != 8'd0 && trig_q[i] == pc) begin
        hit        = 1'b1;
        hit_target = trig_q[i] + {22'd0, skip_q[i], 2'b00};
        hit_cond   = cond_q[i] ? (sparse[rs1_q[i]] || sparse[rs2_q[i]])
                               : (sparse[rs1_q[i]] && sparse[rs2_q[i]]);
      end
    end
  end

  assign fire = state_q == IDLE && if_ex_enable && hit && hit_cond;

  always_ff @(posedge CLK) begin
    if (RST) svrf_q <= 32'h1;
    else svrf_q <= svrf_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (inc_vec[r] && !dec_vec[r] && pend_q[r] != 2'd3) pend_q[r] <= pend_q[r] + 2'd1;
        else if (dec_vec[r] && !inc_vec[r] && pend_q[r] != 2'd0) pend_q[r] <= pend_q[r] - 2'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      trig_q  <= '0;
      valid_q <= '0;
      cond_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      skip_q  <= '0;
    end else if (win_ok) begin
      if (!off[2]) begin
        trig_q[widx] <= {sasa_data[31:2], 2'b00};
      end else begin
        valid_q[widx] <= sasa_data[31];
        cond_q[widx]  <= sasa_data[30];
        rs2_q[widx]   <= sasa_data[20:16];
        rs1_q[widx]   <= sasa_data[12:8];
        skip_q[widx]  <= sasa_data[7:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      skipping_q <= 1'b0;
      target_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (fire) begin
          state_q    <= SKIP;
          skipping_q <= 1'b1;
          target_q   <= hit_target;
        end
        SKIP: begin
          state_q    <= HOLD;
          skipping_q <= 1'b0;
          hold_q     <= '0;
        end
        HOLD: begin
          state_q <= hold_q == HLAST ? IDLE : HOLD;
          hold_q  <= hold_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sparce_target = target_q;
  assign skipping      = skipping_q;
endmodule

// File: tb/tb_sparce_skip_unit.sv
// tb_sparce_skip_unit: directed scenario checks of the SparCE skip unit.
module tb_sparce_skip_unit;
  localparam logic [31:0] BASE = 32'h0000_9000;
  localparam int          HOLD = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] pc = '0, rdata = '0, wb_data = '0, sasa_addr = '0, sasa_data = '0;
  logic        if_ex_enable = 1'b0, wb_en = 1'b0, sasa_wen = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] sparce_target;
  logic        skipping;
  int          n_chk = 0;
  int          n_fail = 0;

  sparce_skip_unit #(.SASA_ENTRIES(4), .SASA_BASE(BASE), .HOLDOFF(HOLD)) dut (
    .CLK(CLK), .RST(RST), .pc(pc), .rdata(rdata), .if_ex_enable(if_ex_enable),
    .wb_en(wb_en), .rd(rd), .wb_data(wb_data), .sasa_wen(sasa_wen),
    .sasa_addr(sasa_addr), .sasa_data(sasa_data),
    .sparce_target(sparce_target), .skipping(skipping)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic sasa_wr(input logic [31:0] a, input logic [31:0] d);
    sasa_wen = 1'b1; sasa_addr = a; sasa_data = d;
    cyc();
    sasa_wen = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; rd = r; wb_data = d;
    cyc();
    wb_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] p, input logic [31:0] ins);
    pc = p; rdata = ins; if_ex_enable = 1'b1;
    cyc();
    if_ex_enable = 1'b0; rdata = '0;
  endtask

  task automatic drain();
    repeat (HOLD + 1) cyc();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) cyc();
    n_chk++; if (skipping !== 1'b0) begin n_fail++; $display("FAIL reset_skipping: got %0b want 0", skipping); end
    n_chk++; if (sparce_target !== 32'h0) begin n_fail++; $display("FAIL reset_target: got %h want 0", sparce_target); end
    RST = 1'b0;
    fetch(32'h100, 32'h0);
    n_chk++; if (skipping !== 1'b0) begin n_fail++; $display("FAIL reset_empty_table: got %0b want 0", skipping); end
  endtask

  task automatic test_and_skip();
    sasa_wr(BASE + 32'h0, 32'h100);
    sasa_wr(BASE + 32'h4, 32'h8006_0504);
    fetch(32'h100, 32'h0);
    n_chk++; if (skipping !== 1'b0) begin n_fail++; $display("FAIL and_not_sparse: got %0b want 0", skipping); end
    wb(5'd5, 32'h0);
    wb(5'd6, 32'h0);
    fetch(32'h100, 32'h0);
    n_chk++; if (skipping !== 1'b1) begin n_fail++; $display("FAIL and_skip: got %0b want 1", skipping); end
    n_chk++; if (sparce_target !== 32'h110) begin n_fail++; $display("FAIL and_target: got %h want 110", sparce_target); end
    cyc();
    n_chk++; if (skipping !== 1'b0) begin n_fail++; $display("FAIL and_one_cycle: got %0b want 0", skipping); end
    n_chk++; if (sparce_target !== 32'h110) begin n_fail++; $display("FAIL and_target_hold: got %h want 110", sparce_target); end
    drain();
  endtask

  task automatic test_cond_or();
    wb(5'd6, 32'h7);
    fetch(32'h100, 32'h0);
    n_chk++; if (skipping !== 1'b0) begin n_fail++; $display("FAIL and_cond_false: got %0b want 0", skipping); end
    sasa_wr(BASE + 32'h4, 32'hC006_0504);
    fetch(32'h100, 32'h0);
    n_chk++; if (skipping !== 1'b1) begin n_fail++; $display("FAIL or_skip: got %0b want 1", skipping); end
    n_chk++; if (sparce_target !== 32'h110) begin n_fail++; $display("FAIL or_target: got %h want 110", sparce_target); end
    drain();
  endtask

  task automatic test_pending_forward();
    fetch(32'hFC, 32'h0000_0293);
    fetch(32'h100, 32'h0);
    n_chk++; if (skipping !== 1'b0) begin n_fail++; $display("FAIL pending_block: got %0b want 0", skipping); end
    wb(5'd5, 32'h0);
    fetch(32'h100, 32'h0);
    n_chk++; if (skipping !== 1'b1) begin n_fail++; $display("FAIL pending_clear: got %0b want 1", skipping); end
    drain();
    sasa_wr(BASE + 32'h4, 32'h8006_0504);
    wb_en = 1'b1; rd = 5'd6; wb_data = 32'h0;
    fetch(32'h100, 32'h0);
    wb_en = 1'b0;
    n_chk++; if (skipping !== 1'b1) begin n_fail++; $display("FAIL fwd_zero: got %0b want 1", skipping); end
    drain();
    wb_en = 1'b1; rd = 5'd6; wb_data = 32'h9;
    fetch(32'h100, 32'h0);
    wb_en = 1'b0;
    n_chk++; if (skipping !== 1'b0) begin n_fail++; $display("FAIL fwd_nonzero: got %0b want 0", skipping); end
  endtask

  task automatic test_priority_holdoff();
    wb(5'd6, 32'h0);
    sasa_wr(BASE + 32'h8, 32'h100);
    sasa_wr(BASE + 32'hC, 32'h8006_0508);
    fetch(32'h100, 32'h0);
    n_chk++; if (sparce_target !== 32'h110 || skipping !== 1'b1) begin n_fail++; $display("FAIL priority: got %h/%0b want 110/1", sparce_target, skipping); end
    cyc();
    fetch(32'h100, 32'h0);
    n_chk++; if (skipping !== 1'b0) begin n_fail++; $display("FAIL holdoff_suppress: got %0b want 0", skipping); end
    cyc();
    fetch(32'h100, 32'h0);
    n_chk++; if (skipping !== 1'b1) begin n_fail++; $display("FAIL holdoff_release: got %0b want 1", skipping); end
    drain();
    pc = 32'h100;
    cyc();
    n_chk++; if (skipping !== 1'b0) begin n_fail++; $display("FAIL no_enable: got %0b want 0", skipping); end
    sasa_wr(BASE + 32'h4, 32'h0006_0504);
    fetch(32'h100, 32'h0);
    n_chk++; if (sparce_target !== 32'h120 || skipping !== 1'b1) begin n_fail++; $display("FAIL entry1_fallback: got %h/%0b want 120/1", sparce_target, skipping); end
    drain();
  endtask

  task automatic test_window();
    sasa_wr(BASE + 32'h20, 32'h300);
    sasa_wr(BASE + 32'h28, 32'h300);
    sasa_wr(BASE - 32'h8, 32'h300);
    fetch(32'h300, 32'h0);
    n_chk++; if (skipping !== 1'b0) begin n_fail++; $display("FAIL window_ignored: got %0b want 0", skipping); end
    fetch(32'h100, 32'h0);
    n_chk++; if (sparce_target !== 32'h120 || skipping !== 1'b1) begin n_fail++; $display("FAIL window_unchanged: got %h/%0b want 120/1", sparce_target, skipping); end
    drain();
  endtask

  task automatic test_fields();
    sasa_wr(BASE + 32'h10, 32'h180);
    sasa_wr(BASE + 32'h14, 32'hC000_0000);
    fetch(32'h180, 32'h0);
    n_chk++; if (skipping !== 1'b0) begin n_fail++; $display("FAIL zero_skip: got %0b want 0", skipping); end
    sasa_wr(BASE + 32'h14, 32'hC000_00FF);
    fetch(32'h180, 32'h0);
    n_chk++; if (sparce_target !== 32'h57C || skipping !== 1'b1) begin n_fail++; $display("FAIL max_skip: got %h/%0b want 57c/1", sparce_target, skipping); end
    drain();
    sasa_wr(BASE + 32'h1B, 32'hFFFF_FFFB);
    sasa_wr(BASE + 32'h1E, 32'hC000_0004);
    fetch(32'hFFFF_FFF8, 32'h0);
    n_chk++; if (sparce_target !== 32'h8 || skipping !== 1'b1) begin n_fail++; $display("FAIL wrap_target: got %h/%0b want 8/1", sparce_target, skipping); end
    drain();
  endtask

  task automatic test_reset_mid();
    fetch(32'h100, 32'h0);
    n_chk++; if (skipping !== 1'b1) begin n_fail++; $display("FAIL pre_reset_skip: got %0b want 1", skipping); end
    RST = 1'b1;
    cyc();
    n_chk++; if (skipping !== 1'b0 || sparce_target !== 32'h0) begin n_fail++; $display("FAIL mid_reset: got %h/%0b want 0/0", sparce_target, skipping); end
    RST = 1'b0;
    fetch(32'h100, 32'h0);
    n_chk++; if (skipping !== 1'b0) begin n_fail++; $display("FAIL table_cleared: got %0b want 0", skipping); end
  endtask

  initial begin
    test_reset();
    test_and_skip();
    test_cond_or();
    test_pending_forward();
    test_priority_holdoff();
    test_window();
    test_fields();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sparce_skip_unit.md
Name: sparce_skip_unit

Overview:
- SparCE sparsity-optimization unit: the `sparce` end of the sparce pipeline interface.
- Consumes fetch PC/instruction, writeback results, SASA config writes and the pipeline advance strobe.
- Tracks which architectural registers hold zero and holds a small software-programmed SASA table of skippable code regions.
- When a fetched trigger PC's sparsity condition is met, it redirects fetch past the region via sparce_target/skipping.

Parameters:
SASA_ENTRIES, 4, number of SASA table entries (power of 2, 1..16)
SASA_BASE, 32'h0000_9000, byte base address of the SASA config window
HOLDOFF, 2, cycles after a skip during which no new skip may fire (>=1)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
pc  in  32  PC of instruction in fetch stage 2
rdata  in  32  instruction word at pc
if_ex_enable  in  1  instruction at pc advances into execute this cycle
wb_en  in  1  register writeback valid
rd  in  5  writeback destination
wb_data  in  32  writeback value
sasa_wen  in  1  SASA config write strobe
sasa_addr  in  32  SASA config byte address
sasa_data  in  32  SASA config write data
sparce_target  out  32  redirect PC
skipping  out  1  redirect fetch to sparce_target

Behaviour:
- Clock is CLK; reset is synchronous, active-high, named RST. All state updates on the rising edge of CLK.
- Reset values:
  - skipping=0, sparce_target=0.
  - SVRF = 32'h1: only x0 marked sparse.
  - All pending counters = 0; all SASA entries invalid; FSM in IDLE.
- SVRF:
  - On wb_en with rd!=0, bit[rd] <= (wb_data==0).
  - Bit 0 is constantly 1.
- Pending scoreboard: 2-bit saturating counter per register 1..31.
  - +1 when if_ex_enable=1 and rdata is a writer with rdata[11:7]!=0.
  - Writer opcodes: 0110111, 0010111, 1101111, 1100111, 0000011, 0010011, 0110011, 1110011.
  - -1 on wb_en for rd, floored at 0.
  - If increment and decrement hit the same register in the same cycle, the counter is unchanged.
  - A register is usable only if its counter is 0. Counts leaked by flushed instructions only suppress skips (safe).
  - At most 2 writers are in flight; saturation at 3 is never reached in correct operation.
- SASA window:
  - off = sasa_addr - SASA_BASE; write accepted only when sasa_wen and off < SASA_ENTRIES*8.
  - entry = off[3+:log2(SASA_ENTRIES)]; off[2]=0 selects word0, off[2]=1 selects word1; off[1:0] ignored.
  - word0 = trigger PC; bits[1:0] are stored as 0.
  - word1 fields:
    - [31] valid
    - [30] cond: 0 = rs1 AND rs2 sparse, 1 = rs1 OR rs2 sparse
    - [20:16] rs2
    - [12:8] rs1
    - [7:0] skip (instructions)
  - Out-of-range writes are ignored.
- Match: an entry matches when valid, skip!=0 and trigger==pc. The lowest-index matching entry wins.
- Sparse(r) = SVRF bit after applying this cycle's writeback (forwarded), AND pending counter for r is 0. r=0 is always sparse.
- A SASA write in the same cycle as a lookup: the lookup uses the old table contents.
- FSM:
  - IDLE: if if_ex_enable and match and cond true -> SKIP. On that edge:
    - sparce_target <= trigger + (skip<<2), with 32-bit wrap.
    - skipping <= 1.
  - SKIP (skipping=1 for exactly one cycle) -> HOLD. On that edge skipping <= 0.
  - HOLD: count HOLDOFF cycles, evaluate no triggers, then -> IDLE.
  - Latency: trigger presented in cycle N -> skipping high in cycle N+1.
  - sparce_target holds its last value while skipping=0.
- if_ex_enable=0: no lookup and no pending increment. The HOLD counter still advances.
- RST asserted mid-skip: all outputs and state return to reset values at the next edge, overriding every other update.

Test Plan:
- Reset check: assert RST for 2 cycles -> skipping=0, sparce_target=0, SVRF=1; pc=0x100 presented with no table entries -> no skip.
- AND skip:
  - Program entry0: word0=0x100, word1=0x8006_0504 (AND, rs1=5, rs2=6, skip=4). Write back x5=0 and x6=0.
  - Present pc=0x100, if_ex_enable=1 -> next cycle skipping=1 for one cycle, sparce_target=0x110.
- Condition false / OR:
  - With x6=7, same entry -> no skip.
  - Rewrite word1=0xC006_0504 (OR) -> skipping=1, target 0x110.
- Pending and forwarding:
  - Fetch rdata=0x00000293 (addi x5,x0,0) at 0xFC, then 0x100 -> no skip.
  - After wb x5=0, present 0x100 again -> skip.
  - wb x6=9 in the same cycle as the 0x100 lookup -> no skip (AND).
- Holdoff/priority:
  - Entries 0 and 1 both trigger on 0x100 with skips 4 and 8 -> target 0x110 (entry0 wins).
  - Re-present 0x100 in the cycle after skipping falls -> suppressed; presenting it after HOLDOFF cycles -> skips again.
- Window bounds: write to SASA_BASE+0x20 with 4 entries -> ignored; table unchanged, no skip.
